// File: rtl/cpu_pc_seq.sv
// -----------------------------------------------------------------------------
// cpu_pc_seq
//   Program-counter sequencer for an 8008-style CPU. Accepts decoded control
//   transfer opcodes (jump, call, return, restart with their conditional
//   forms), collects the two address operand bytes where needed, and updates
//   the 14-bit program counter and an 8-entry circular return stack.
//
// Handshake
//   An opcode transfers on a rising edge where op_valid && op_ready. The
//   producer holds opcode/flags stable while op_valid is high. op_ready is
//   high only in IDLE. An operand byte transfers on an edge where byte_valid
//   is high while the FSM waits in ADDR_LO or ADDR_HI. There is no
//   backpressure on operand bytes. Valids offered in any other state are
//   ignored.
//
// Ports
//   clk         in   1   rising-edge clock
//   rst         in   1   synchronous, active-high reset
//   op_valid    in   1   decoded opcode offered
//   op_ready    out  1   sequencer can accept an opcode (IDLE only)
//   opcode      in   8   opcode byte, 8008 encoding
//   byte_valid  in   1   address operand byte present on op_byte
//   op_byte     in   8   operand byte: low byte first, then high byte
//   flags       in   4   [0]=C [1]=Z [2]=S [3]=P, sampled with the opcode
//   inc         in   1   fetch-advance strobe, PC+1
//   pc          out  14  program counter
//   sp          out  3   stack write pointer
//   depth       out  4   valid stack entries, 0..8
//   taken       out  1   one-cycle pulse when a control transfer loads PC
//   ovf         out  1   sticky stack overflow
//   unf         out  1   sticky stack underflow
//   fsm_state   out  2   debug view of the FSM: 0=IDLE 1=ADDR_LO 2=ADDR_HI 3=EXEC
// -----------------------------------------------------------------------------
module cpu_pc_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [7:0]  opcode,
    input  logic        byte_valid,
    input  logic [7:0]  op_byte,
    input  logic [3:0]  flags,
    input  logic        inc,
    output logic [13:0] pc,
    output logic [2:0]  sp,
    output logic [3:0]  depth,
    output logic        taken,
    output logic        ovf,
    output logic        unf,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR_LO = 2'd1,
        S_ADDR_HI = 2'd2,
        S_EXEC    = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        K_NONE = 3'd0,
        K_JUMP = 3'd1,
        K_CALL = 3'd2,
        K_RET  = 3'd3,
        K_RST  = 3'd4
    } kind_t;

    // -------------------------------------------------------------------------
    // Opcode decode
    // -------------------------------------------------------------------------
    // Bits [7:6] pick the group, bits [2:0] the operation within it. Jumps and
    // calls live in group 01, returns and restarts in group 00.
    function automatic kind_t decode_kind(input logic [7:0] op);
        kind_t k;
        k = K_NONE;
        if (op[7:6] == 2'b01) begin
            case (op[2:0])
                3'b100, 3'b000: k = K_JUMP;
                3'b110, 3'b010: k = K_CALL;
                default:        k = K_NONE;
            endcase
        end else if (op[7:6] == 2'b00) begin
            case (op[2:0])
                3'b111, 3'b011: k = K_RET;
                3'b101:         k = K_RST;
                default:        k = K_NONE;
            endcase
        end
        return k;
    endfunction

    // Conditional forms are the ones whose low bits are 000 (jump), 010 (call)
    // or 011 (return). Bit 5 selects the polarity: 0 = take on flag clear,
    // 1 = take on flag set. Bits [4:3] select the flag.
    function automatic logic cond_pass(input logic [7:0] op, input logic [3:0] flg);
        logic is_cond;
        logic flag_bit;
        is_cond  = (op[2:0] == 3'b000) || (op[2:0] == 3'b010) || (op[2:0] == 3'b011);
        flag_bit = flg[op[4:3]];
        if (!is_cond) begin
            return 1'b1;
        end
        return op[5] ? flag_bit : ~flag_bit;
    endfunction

    // -------------------------------------------------------------------------
    // State and storage
    // -------------------------------------------------------------------------
    state_t      state;
    state_t      state_next;

    logic [7:0]  op_q;          // opcode held for the whole instruction
    logic [3:0]  flags_q;       // flags sampled with the opcode
    logic [7:0]  addr_lo;
    logic [5:0]  addr_hi;
    logic [13:0] stack_mem [0:7];

    logic        accept;
    kind_t       exec_kind;
    logic        exec_take;
    logic        do_push;
    logic        do_pop;
    logic [13:0] target;
    logic [2:0]  sp_dec;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    accept = 1'b1;
                    case (decode_kind(opcode))
                        K_JUMP, K_CALL: state_next = S_ADDR_LO;
                        K_RET, K_RST:   state_next = S_EXEC;
                        // Anything else is consumed without effect.
                        default:        state_next = S_IDLE;
                    endcase
                end
            end
            S_ADDR_LO: begin
                if (byte_valid) begin
                    state_next = S_ADDR_HI;
                end
            end
            S_ADDR_HI: begin
                if (byte_valid) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign fsm_state = state;

    // -------------------------------------------------------------------------
    // Execute-stage decode of the held opcode
    // -------------------------------------------------------------------------
    always_comb begin
        exec_kind = decode_kind(op_q);
        exec_take = (state == S_EXEC) && (exec_kind != K_NONE) && cond_pass(op_q, flags_q);
        do_push   = exec_take && ((exec_kind == K_CALL) || (exec_kind == K_RST));
        do_pop    = exec_take && (exec_kind == K_RET);
        sp_dec    = sp - 3'd1;
        target    = '0;
        case (exec_kind)
            K_JUMP, K_CALL: target = {addr_hi, addr_lo};
            K_RST:          target = {8'b0, op_q[5:3], 3'b000};
            K_RET:          target = stack_mem[sp_dec];
            default:        target = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: operand capture, PC, stack, status
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            flags_q <= '0;
            addr_lo <= '0;
            addr_hi <= '0;
            pc      <= '0;
            sp      <= '0;
            depth   <= '0;
            taken   <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                stack_mem[i] <= '0;
            end
        end else begin
            taken <= 1'b0;

            if (accept) begin
                op_q    <= opcode;
                flags_q <= flags;
            end

            if ((state == S_ADDR_LO) && byte_valid) begin
                addr_lo <= op_byte;
            end
            // The high address byte only has six meaningful bits.
            if ((state == S_ADDR_HI) && byte_valid) begin
                addr_hi <= op_byte[5:0];
            end

            // A transfer load overrides a coincident fetch increment.
            if (exec_take) begin
                pc    <= target;
                taken <= 1'b1;
            end else if (inc) begin
                pc <= pc + 14'd1;
            end

            // The stack is circular: a push when full overwrites the oldest
            // entry, which is the slot sp already points at.
            if (do_push) begin
                stack_mem[sp] <= pc;
                sp            <= sp + 3'd1;
                if (depth == 4'd8) begin
                    ovf <= 1'b1;
                end else begin
                    depth <= depth + 4'd1;
                end
            end

            // An empty pop still moves sp and loads whatever sits in the slot.
            if (do_pop) begin
                sp <= sp_dec;
                if (depth == 4'd0) begin
                    unf <= 1'b1;
                end else begin
                    depth <= depth - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_pc_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_pc_seq
//   Directed bench for cpu_pc_seq. Inputs change 1 time unit after a rising
//   edge; outputs are checked at that same point, well away from the edge.
// -----------------------------------------------------------------------------
module tb_cpu_pc_seq;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  opcode;
    logic        byte_valid;
    logic [7:0]  op_byte;
    logic [3:0]  flags;
    logic        inc;
    logic [13:0] pc;
    logic [2:0]  sp;
    logic [3:0]  depth;
    logic        taken;
    logic        ovf;
    logic        unf;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ADDR_LO = 2'd1;
    localparam logic [1:0] ST_ADDR_HI = 2'd2;
    localparam logic [1:0] ST_EXEC    = 2'd3;

    cpu_pc_seq dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .opcode     (opcode),
        .byte_valid (byte_valid),
        .op_byte    (op_byte),
        .flags      (flags),
        .inc        (inc),
        .pc         (pc),
        .sp         (sp),
        .depth      (depth),
        .taken      (taken),
        .ovf        (ovf),
        .unf        (unf),
        .fsm_state  (fsm_state)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Driver tasks
    task automatic do_op(input logic [7:0] op, input logic [3:0] flg);
        int n;
        n = 0;
        while (!op_ready && n < 20) begin
            tick();
            n++;
        end
        check("op_ready_wait", {15'b0, op_ready}, 16'h1);
        opcode   = op;
        flags    = flg;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic do_byte(input logic [7:0] b);
        op_byte    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic pulse_inc();
        inc = 1'b1;
        tick();
        inc = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        op_valid   = 1'b0;
        opcode     = '0;
        byte_valid = 1'b0;
        op_byte    = '0;
        flags      = '0;
        inc        = 1'b1;   // reset must win over inc
        tick();
        tick();
        check("rst_pc",    {2'b0, pc}, 16'h0000);
        check("rst_sp",    {13'b0, sp}, 16'h0);
        check("rst_depth", {12'b0, depth}, 16'h0);
        check("rst_taken", {15'b0, taken}, 16'h0);
        check("rst_ovf",   {15'b0, ovf}, 16'h0);
        check("rst_unf",   {15'b0, unf}, 16'h0);
        check("rst_state", {14'b0, fsm_state}, {14'b0, ST_IDLE});
        inc = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_ready", {15'b0, op_ready}, 16'h1);

        // JMP 0x44 -> 0x1234
        do_op(8'h44, 4'h0);
        check("jmp_state_lo", {14'b0, fsm_state}, {14'b0, ST_ADDR_LO});
        check("jmp_not_ready", {15'b0, op_ready}, 16'h0);
        do_byte(8'h34);
        check("jmp_state_hi", {14'b0, fsm_state}, {14'b0, ST_ADDR_HI});
        do_byte(8'h92);
        check("jmp_state_exec", {14'b0, fsm_state}, {14'b0, ST_EXEC});
        check("jmp_taken_pre", {15'b0, taken}, 16'h0);
        tick();
        check("jmp_pc", {2'b0, pc}, 16'h1234);
        check("jmp_taken", {15'b0, taken}, 16'h1);
        check("jmp_state_idle", {14'b0, fsm_state}, {14'b0, ST_IDLE});
        tick();
        check("jmp_taken_end", {15'b0, taken}, 16'h0);
        check("jmp_pc_hold", {2'b0, pc}, 16'h1234);

        // INC in IDLE, then INC mid-sequence with an ignored op_valid
        pulse_inc();
        check("inc_idle", {2'b0, pc}, 16'h1235);
        do_op(8'h44, 4'h0);
        op_valid = 1'b1;
        opcode   = 8'h07;
        pulse_inc();
        op_valid = 1'b0;
        check("inc_mid_pc", {2'b0, pc}, 16'h1236);
        check("inc_mid_state", {14'b0, fsm_state}, {14'b0, ST_ADDR_LO});
        do_byte(8'h00);
        do_byte(8'h01);
        tick();
        check("jmp100_pc", {2'b0, pc}, 16'h0100);

        // CALL 0x46 -> 0x2000, then RET
        do_op(8'h46, 4'h0);
        do_byte(8'h00);
        do_byte(8'h20);
        tick();
        check("call_pc", {2'b0, pc}, 16'h2000);
        check("call_sp", {13'b0, sp}, 16'h1);
        check("call_depth", {12'b0, depth}, 16'h1);
        check("call_taken", {15'b0, taken}, 16'h1);
        check("call_stack0", {2'b0, dut.stack_mem[0]}, 16'h0100);
        do_op(8'h07, 4'h0);
        check("ret_state_exec", {14'b0, fsm_state}, {14'b0, ST_EXEC});
        tick();
        check("ret_pc", {2'b0, pc}, 16'h0100);
        check("ret_sp", {13'b0, sp}, 16'h0);
        check("ret_depth", {12'b0, depth}, 16'h0);
        check("ret_taken", {15'b0, taken}, 16'h1);

        // Conditional jumps with Z=1
        do_op(8'h48, 4'h2);
        do_byte(8'h00);
        do_byte(8'h10);
        tick();
        check("jfz_pc", {2'b0, pc}, 16'h0100);
        check("jfz_taken", {15'b0, taken}, 16'h0);
        do_op(8'h68, 4'h2);
        do_byte(8'h00);
        do_byte(8'h10);
        tick();
        check("jtz_pc", {2'b0, pc}, 16'h1000);
        check("jtz_taken", {15'b0, taken}, 16'h1);

        // Non-transfer opcode is consumed, stays in IDLE
        do_op(8'hC0, 4'h0);
        check("nop_state", {14'b0, fsm_state}, {14'b0, ST_IDLE});
        check("nop_pc", {2'b0, pc}, 16'h1000);

        // RFz with Z=1: not taken, no underflow
        do_op(8'h0B, 4'h2);
        tick();
        check("rfz_pc", {2'b0, pc}, 16'h1000);
        check("rfz_taken", {15'b0, taken}, 16'h0);
        check("rfz_sp", {13'b0, sp}, 16'h0);
        check("rfz_unf", {15'b0, unf}, 16'h0);

        // Nine RST 7: overflow wraps and overwrites stack[0]
        for (int i = 0; i < 9; i++) begin
            do_op(8'h3D, 4'h0);
            tick();
        end
        check("rst9_pc", {2'b0, pc}, 16'h0038);
        check("rst9_depth", {12'b0, depth}, 16'h8);
        check("rst9_ovf", {15'b0, ovf}, 16'h1);
        check("rst9_sp", {13'b0, sp}, 16'h1);
        pulse_inc();
        pulse_inc();
        check("rst9_inc", {2'b0, pc}, 16'h003A);
        do_op(8'h07, 4'h0);
        tick();
        check("ovf_ret_pc", {2'b0, pc}, 16'h0038);
        check("ovf_ret_sp", {13'b0, sp}, 16'h0);
        check("ovf_ret_depth", {12'b0, depth}, 16'h7);

        // Reset, then RET from empty stack with INC during EXEC
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_ovf", {15'b0, ovf}, 16'h0);
        check("rst2_depth", {12'b0, depth}, 16'h0);
        pulse_inc();
        pulse_inc();
        pulse_inc();
        check("unf_pre_pc", {2'b0, pc}, 16'h0003);
        do_op(8'h07, 4'h0);
        inc = 1'b1;
        tick();
        inc = 1'b0;
        check("unf_pc", {2'b0, pc}, 16'h0000);
        check("unf_flag", {15'b0, unf}, 16'h1);
        check("unf_depth", {12'b0, depth}, 16'h0);
        check("unf_sp", {13'b0, sp}, 16'h7);
        check("unf_taken", {15'b0, taken}, 16'h1);

        // Reset while in ADDR_HI aborts the jump
        pulse_inc();
        do_op(8'h44, 4'h0);
        do_byte(8'h34);
        check("abort_state_hi", {14'b0, fsm_state}, {14'b0, ST_ADDR_HI});
        rst        = 1'b1;
        byte_valid = 1'b1;
        op_byte    = 8'h92;
        tick();
        rst        = 1'b0;
        byte_valid = 1'b0;
        check("abort_state", {14'b0, fsm_state}, {14'b0, ST_IDLE});
        check("abort_pc", {2'b0, pc}, 16'h0000);
        check("abort_ready", {15'b0, op_ready}, 16'h1);
        check("abort_unf", {15'b0, unf}, 16'h0);
        tick();
        check("abort_taken", {15'b0, taken}, 16'h0);
        check("abort_pc_hold", {2'b0, pc}, 16'h0000);
        do_op(8'h44, 4'h0);
        do_byte(8'h78);
        do_byte(8'hC1);   // bits [7:6] ignored
        tick();
        check("post_abort_pc", {2'b0, pc}, 16'h0178);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_pc_seq.md
CPU_PC_SEQ -- requirements
Module: cpu_pc_seq

Interface
REQ-001 Synchronous active-high reset; one clock.
REQ-002 CLK_I  in  1  rising-edge clock.
REQ-003 RST_I  in  1  reset; synchronous, active-high.
REQ-004 OP_VALID_I  in  1  decoded opcode offered.
REQ-005 OP_READY_O  out  1  sequencer can accept an opcode; high only in IDLE.
REQ-006 OPCODE_I  in  8  opcode byte (8008 encoding).
REQ-007 BYTE_VALID_I  in  1  address operand byte present on BYTE_I.
REQ-008 BYTE_I  in  8  operand byte; low byte first, then high byte.
REQ-009 FLAGS_I  in  4  [0]=C, [1]=Z, [2]=S, [3]=P.
REQ-010 INC_I  in  1  fetch-advance strobe: PC+1.
REQ-011 PC_O  out  14  program counter.
REQ-012 SP_O  out  3  stack write pointer.
REQ-013 DEPTH_O  out  4  valid stack entries, 0..8.
REQ-014 TAKEN_O  out  1  one-cycle pulse when a control transfer loads PC.
REQ-015 OVF_O / UNF_O  out  1 each  sticky stack overflow / underflow.

Function
REQ-016 Opcode accepted on an edge where OP_VALID_I && OP_READY_O; FLAGS_I sampled on that edge and held for the instruction.
REQ-017 Decoding: JMP 01xxx100; JFc 010cc000; JTc 011cc000; CALL 01xxx110; CFc 010cc010; CTc 011cc010; RET 00xxx111; RFc 000cc011; RTc 001cc011; RST 00aaa101; cc 00=C, 01=Z, 10=S, 11=P.
REQ-018 Condition: F-forms are taken when the flag is 0; T-forms when the flag is 1; unconditional forms are always taken.
REQ-019 FSM states: IDLE, ADDR_LO, ADDR_HI, EXEC.
REQ-020 IDLE: a jump or call goes to ADDR_LO; RET, RST and conditional returns go to EXEC; any other opcode is consumed with no effect and the FSM stays in IDLE.
REQ-021 ADDR_LO waits for BYTE_VALID_I, latches the low byte, then goes to ADDR_HI; ADDR_HI waits for BYTE_VALID_I, latches BYTE_I[5:0] (bits [7:6] ignored), then goes to EXEC.
REQ-022 EXEC lasts exactly one cycle, then returns to IDLE; PC_O and TAKEN_O update on the edge ending EXEC.
REQ-023 Taken jump: PC = {hi[5:0], lo}.
REQ-024 Taken call: stack[SP] = PC_O as seen in EXEC; SP = SP+1 mod 8; then PC = target.
REQ-025 Taken return: SP = SP-1 mod 8; PC = stack[SP-1].
REQ-026 RST: push as for a call; PC = {8'b0, aaa, 3'b000}.
REQ-027 Not taken: PC, SP and the stack are unchanged; TAKEN_O stays 0.
REQ-028 INC_I advances PC by 1 mod 2^14 in any state, including mid-sequence.
REQ-029 If INC_I coincides with a taken transfer, the transfer load wins and that increment is dropped.
REQ-030 Depth: +1 on push, saturating at 8; -1 on pop, saturating at 0.
REQ-031 Push at depth 8: OVF_O is set and the oldest entry is overwritten (circular); depth stays 8.
REQ-032 Pop at depth 0: UNF_O is set and PC still loads the wrapped entry; depth stays 0.
REQ-033 OVF_O and UNF_O clear only on reset.
REQ-034 OP_VALID_I and BYTE_VALID_I are ignored in any state that does not consume them.

Reset
REQ-035 While RST_I is high on an edge: PC_O=0, SP_O=0, DEPTH_O=0, all stack entries=0, TAKEN_O=0, OVF_O=0, UNF_O=0, FSM=IDLE.
REQ-036 Reset mid-sequence aborts the instruction and discards latched operand bytes; OP_READY_O=1 on the first edge after RST_I falls.
REQ-037 RST_I has priority over INC_I and over any transfer.

Verification
REQ-038 Bench: reset, then JMP 0x44 with bytes 0x34, 0x92 -> PC_O=0x1234 after EXEC; TAKEN_O pulses for 1 cycle.
REQ-039 Bench: PC=0x0100, CALL 0x46 with bytes 0x00, 0x20 -> stack[0]=0x0100, SP_O=1, PC_O=0x2000; then RET 0x07 -> PC_O=0x0100, SP_O=0, DEPTH_O=0.
REQ-040 Bench: FLAGS_I=0x2 (Z=1); JFz 0x48 with bytes 0x00, 0x10 -> not taken, PC unchanged; JTz 0x68 with the same bytes -> PC_O=0x1000.
REQ-041 Bench: nine RST 0x3D (aaa=7) -> PC_O=0x0038, DEPTH_O=8, OVF_O=1, SP_O=1.
REQ-042 Bench: RET from depth 0 -> UNF_O=1, DEPTH_O=0, SP_O=7; INC_I asserted in the same cycle as EXEC -> load wins, no increment.
REQ-043 Bench: RST_I asserted in ADDR_HI -> FSM=IDLE, PC_O=0, and no transfer occurs.
